// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if
//   Bundle between the ID/EX pipeline side and the EX-stage multiply/divide unit.
//   master : pipeline side, drives op_valid/funct/rs_data/rt_data and observes
//            busy/stall_req/hilo_rdata/hi/lo.
//   slave  : ex_muldiv_unit.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             stall_req;
  logic [WIDTH-1:0] hilo_rdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, funct, rs_data, rt_data,
    input  busy, stall_req, hilo_rdata, hi, lo
  );

  modport slave (
    input  op_valid, funct, rs_data, rt_data,
    output busy, stall_req, hilo_rdata, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   EX-stage iterative multiply/divide unit owning the HI/LO registers.
//   MULT/MULTU run as shift-add, DIV/DIVU as restoring division, one bit per
//   cycle; MFHI/MFLO/MTHI/MTLO are served directly.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high
//   mdu    : ex_muldiv_unit_if.slave
//            in  op_valid, funct, rs_data, rt_data
//            out busy (op in flight), stall_req (HI/LO op while busy),
//                hilo_rdata (MFHI->hi, MFLO->lo, else 0), hi, lo
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  ex_muldiv_unit_if.slave mdu
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  // acc/lo_r form {product_hi, product_lo} for multiply and
  // {remainder, quotient/dividend} for divide.
  logic [WIDTH-1:0] acc, lo_r;
  logic [WIDTH-1:0] opa, opb, raw_rs;
  logic             is_div, neg_res, neg_rem, div_zero;

  logic             hilo_class, accept, sgn_a, sgn_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    hilo_class = mdu.op_valid &&
                 ((mdu.funct[5:2] == 4'b0100) || (mdu.funct[5:2] == 4'b0110));
    accept     = hilo_class && !busy_q;
    // Even functs of the 18h..1Bh group are the signed variants.
    sgn_a      = !mdu.funct[0] && mdu.rs_data[WIDTH-1];
    sgn_b      = !mdu.funct[0] && mdu.rt_data[WIDTH-1];
    abs_a      = sgn_a ? (~mdu.rs_data + 1'b1) : mdu.rs_data;
    abs_b      = sgn_b ? (~mdu.rt_data + 1'b1) : mdu.rt_data;

    mul_sum    = {1'b0, acc} + (lo_r[0] ? {1'b0, opa} : '0);
    div_shift  = {acc, lo_r[WIDTH-1]};
    div_ge     = div_shift >= {1'b0, opb};
    // Remainder before the shift is < opb, so the difference fits WIDTH bits.
    div_diff   = div_shift[WIDTH-1:0] - opb;

    prod       = {acc, lo_r};
    prod_fix   = neg_res ? (~prod + 1'b1) : prod;
    quo_fix    = neg_res ? (~lo_r + 1'b1) : lo_r;
    rem_fix    = neg_rem ? (~acc + 1'b1) : acc;
  end

  always_comb begin
    mdu.hilo_rdata = '0;
    if (mdu.funct == F_MFHI)      mdu.hilo_rdata = hi_q;
    else if (mdu.funct == F_MFLO) mdu.hilo_rdata = lo_q;
  end

  assign mdu.busy      = busy_q;
  assign mdu.stall_req = hilo_class && busy_q;
  assign mdu.hi        = hi_q;
  assign mdu.lo        = lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc      <= '0;
      lo_r     <= '0;
      opa      <= '0;
      opb      <= '0;
      raw_rs   <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (mdu.funct)
              F_MTHI: hi_q <= mdu.rs_data;
              F_MTLO: lo_q <= mdu.rs_data;
              F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                opa      <= abs_a;
                opb      <= abs_b;
                raw_rs   <= mdu.rs_data;
                is_div   <= mdu.funct[1];
                neg_res  <= sgn_a ^ sgn_b;
                neg_rem  <= sgn_a;
                div_zero <= (mdu.rt_data == '0);
                acc      <= '0;
                // Multiplier shifts out of lo_r; dividend shifts out of lo_r.
                lo_r     <= mdu.funct[1] ? abs_a : abs_b;
                count    <= '0;
                busy_q   <= 1'b1;
                state    <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (is_div) begin
            acc  <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_r <= {lo_r[WIDTH-2:0], div_ge};
          end else begin
            {acc, lo_r} <= {mul_sum, lo_r[WIDTH-1:1]};
          end
          if (count == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi_q <= raw_rs;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit
//   Directed-vector bench for ex_muldiv_unit with hand-computed expectations.
module tb_ex_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.WIDTH(W)) mdu ();
  ex_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .mdu(mdu));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issue one op for a single cycle, count busy cycles, check HI/LO.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    @(negedge clk);
    mdu.op_valid = 1'b1; mdu.funct = f; mdu.rs_data = a; mdu.rt_data = b;
    @(negedge clk);
    mdu.op_valid = 1'b0; mdu.funct = 6'h00;
    n = 0;
    while (mdu.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'd33);
    chk({tag, " hi"}, 64'(mdu.hi), 64'(ehi));
    chk({tag, " lo"}, 64'(mdu.lo), 64'(elo));
  endtask

  initial begin
    int n;
    mdu.op_valid = 1'b0; mdu.funct = 6'h00; mdu.rs_data = '0; mdu.rt_data = '0;
    reset = 1'b1;
    #12;
    chk("rst busy", 64'(mdu.busy), 64'd0);
    chk("rst stall", 64'(mdu.stall_req), 64'd0);
    chk("rst hi", 64'(mdu.hi), 64'd0);
    chk("rst lo", 64'(mdu.lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mult 7*-3", 6'h18, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    run_op("multu max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    // Busy just fell: MFHI in this cycle must not stall and sees the result.
    mdu.op_valid = 1'b1; mdu.funct = 6'h10;
    #1;
    chk("mfhi stall", 64'(mdu.stall_req), 64'd0);
    chk("mfhi data", 64'(mdu.hilo_rdata), 64'hFFFF_FFFE);
    mdu.op_valid = 1'b0; mdu.funct = 6'h00;

    run_op("div -7/2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 100/7", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div 5/0", 6'h1A, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("divu 9/0", 6'h1B, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
    run_op("div ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("div 7/-2", 6'h1A, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

    // MFLO one cycle behind MULT 3*4 stalls until busy drops.
    @(negedge clk);
    mdu.op_valid = 1'b1; mdu.funct = 6'h18; mdu.rs_data = 32'd3; mdu.rt_data = 32'd4;
    @(negedge clk);
    mdu.funct = 6'h12; mdu.rs_data = 32'hDEAD_BEEF; mdu.rt_data = 32'h0;
    #1;
    chk("mflo stall first", 64'(mdu.stall_req), 64'd1);
    n = 0;
    while (mdu.stall_req === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("mflo stall cycles", 64'(n), 64'd33);
    chk("mflo busy", 64'(mdu.busy), 64'd0);
    chk("mflo data", 64'(mdu.hilo_rdata), 64'd12);
    @(negedge clk);
    mdu.op_valid = 1'b0; mdu.funct = 6'h00;

    // Non HI/LO funct (ADD 20h) never stalls and leaves HI/LO alone.
    mdu.op_valid = 1'b1; mdu.funct = 6'h20; mdu.rs_data = 32'h55;
    #1;
    chk("add stall", 64'(mdu.stall_req), 64'd0);
    chk("add rdata", 64'(mdu.hilo_rdata), 64'd0);
    @(negedge clk);
    chk("add lo kept", 64'(mdu.lo), 64'd12);
    chk("add busy", 64'(mdu.busy), 64'd0);

    // MTLO while idle.
    mdu.funct = 6'h13; mdu.rs_data = 32'h1234;
    #1;
    chk("mtlo stall", 64'(mdu.stall_req), 64'd0);
    @(negedge clk);
    mdu.op_valid = 1'b0; mdu.funct = 6'h00;
    chk("mtlo lo", 64'(mdu.lo), 64'h1234);
    chk("mtlo busy", 64'(mdu.busy), 64'd0);

    // MTHI while idle.
    mdu.op_valid = 1'b1; mdu.funct = 6'h11; mdu.rs_data = 32'hABCD;
    @(negedge clk);
    mdu.op_valid = 1'b0; mdu.funct = 6'h00;
    chk("mthi hi", 64'(mdu.hi), 64'hABCD);

    // Reset mid-operation.
    mdu.op_valid = 1'b1; mdu.funct = 6'h19; mdu.rs_data = 32'h1234_5678; mdu.rt_data = 32'h9ABC_DEF0;
    @(negedge clk);
    mdu.op_valid = 1'b0; mdu.funct = 6'h00;
    repeat (10) @(negedge clk);
    chk("pre-rst busy", 64'(mdu.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst busy", 64'(mdu.busy), 64'd0);
    chk("midrst hi", 64'(mdu.hi), 64'd0);
    chk("midrst lo", 64'(mdu.lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("multu 2*3", 6'h19, 32'd2, 32'd3, 32'd0, 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
